// File: rtl/row_stream_reader.sv
// Frame reader: walks rows 0..NUM_ROWS-1 through a 1-cycle synchronous memory and
// streams them out through a 2-entry FIFO with credit-gated read issue.
module row_stream_reader #(
    parameter int NUM_ROWS  = 8,
    parameter int ROW_WIDTH = 32,
    parameter int PTR_BITS  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [PTR_BITS-1:0]  rd_addr,
    input  logic [ROW_WIDTH-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_WIDTH-1:0] out_data,
    output logic [PTR_BITS-1:0]  out_row,
    output logic                 out_last
);

    localparam int CNT_W = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0]    ROWS_CNT  = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0]    FINAL_CNT = CNT_W'(NUM_ROWS - 1);
    localparam logic [PTR_BITS-1:0] LAST_ROW  = PTR_BITS'(NUM_ROWS - 1);
    localparam int ENT_W = ROW_WIDTH + PTR_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic                done_q, done_d;
    logic                inflight_q;
    logic [PTR_BITS-1:0] ret_row_q;
    logic [1:0]          count_q, count_d;
    logic [ENT_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ENT_W-1:0]    push_ent;
    logic                pop, push, last_pop;
    logic [2:0]          occ;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;
    assign push_ent  = {rd_data, ret_row_q, (ret_row_q == LAST_ROW)};
    assign {out_data, out_row, out_last} = head_q;
    assign last_pop  = pop & out_last;

    // Credit: entries held plus the read in flight, net of this cycle's pop, must leave room.
    assign occ     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en   = (state_q == RUN) && (issued_q < ROWS_CNT) && (occ < 3'd2);
    assign rd_addr = issued_q[PTR_BITS-1:0];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    issued_d = '0;
                end
            end
            RUN: begin
                if (rd_en) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q == FINAL_CNT) state_d = DRAIN;
                end
                if (last_pop) begin
                    state_d  = IDLE;
                    issued_d = '0;
                    done_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d  = IDLE;
                    issued_d = '0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_ent;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_ent;
                end else if (push) begin
                    tail_d  = push_ent;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = push_ent;
                    else      count_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            ret_row_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            inflight_q <= rd_en;
            if (rd_en) ret_row_q <= rd_addr;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_row_stream_reader.sv
// Bench for row_stream_reader: 4-row and 1-row instances, with a frame-level
// reference model (expected row sequence, outstanding-credit count, busy/done timing).
module tb_row_stream_reader;

    logic clk;
    logic rst_n;

    logic       start4, ready4, busy4, done4, rd_en4, valid4, last4;
    logic [1:0] rd_addr4, row4;
    logic [7:0] rd_data4, data4;

    logic       start1, ready1, busy1, done1, rd_en1, valid1, last1;
    logic [0:0] rd_addr1, row1;
    logic [7:0] rd_data1, data1;

    logic [7:0] mem4 [0:3];
    logic [7:0] mem1_word;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit   m_busy, m_done_exp, p_hold;
    int   m_rd_k, m_pop_k, m_out;
    logic [7:0] p_data;
    logic [1:0] p_row;
    logic       p_last;
    bit   o_valid, o_rd, o_done;
    logic [7:0] o_data;
    int   n_reads, n_pops, n_done;

    row_stream_reader #(.NUM_ROWS(4), .ROW_WIDTH(8)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .out_valid(valid4), .out_ready(ready4), .out_data(data4),
        .out_row(row4), .out_last(last4)
    );

    row_stream_reader #(.NUM_ROWS(1), .ROW_WIDTH(8)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_row(row1), .out_last(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous row memories, one cycle of read latency
    always @(posedge clk) begin
        if (rd_en4) rd_data4 <= mem4[rd_addr4];
        if (rd_en1) rd_data1 <= mem1_word;
    end

    task automatic clear_counts();
        n_reads = 0;
        n_pops  = 0;
        n_done  = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_done_exp = 0; p_hold = 0;
        m_rd_k = 0; m_pop_k = 0; m_out = 0;
    endtask

    // One cycle on the 4-row instance: drive, sample, compare to the model, advance the model.
    task automatic step4(input logic st, input logic rdy);
        bit popped_last;
        @(negedge clk);
        start4 = st;
        ready4 = rdy;
        #1;
        o_valid = valid4; o_rd = rd_en4; o_done = done4; o_data = data4;
        checks++;
        if (busy4 !== m_busy) begin
            errors++; $display("FAIL busy: got %b expected %b at %0t", busy4, m_busy, $time);
        end
        checks++;
        if (done4 !== m_done_exp) begin
            errors++; $display("FAIL done: got %b expected %b at %0t", done4, m_done_exp, $time);
        end
        if (!m_busy) begin
            checks++;
            if (valid4 !== 1'b0) begin
                errors++; $display("FAIL idle_valid: got %b expected 0 at %0t", valid4, $time);
            end
        end
        if (p_hold) begin
            checks++;
            if (valid4 !== 1'b1 || data4 !== p_data || row4 !== p_row || last4 !== p_last) begin
                errors++;
                $display("FAIL hold: got v%b %h/%0d/%b expected v1 %h/%0d/%b at %0t",
                         valid4, data4, row4, last4, p_data, p_row, p_last, $time);
            end
        end
        popped_last = 0;
        if (valid4 === 1'b1 && rdy) begin
            checks++;
            if (m_pop_k >= 4 || data4 !== mem4[2'(m_pop_k)] || row4 !== 2'(m_pop_k)
                || last4 !== (m_pop_k == 3)) begin
                errors++;
                $display("FAIL beat: got %h/%0d/%b expected row %0d at %0t",
                         data4, row4, last4, m_pop_k, $time);
            end
            n_pops++;
            m_pop_k++;
            m_out--;
            popped_last = (m_pop_k == 4);
        end
        if (rd_en4 === 1'b1) begin
            checks++;
            if (!m_busy || m_rd_k >= 4 || rd_addr4 !== 2'(m_rd_k)) begin
                errors++;
                $display("FAIL read: got addr %0d expected %0d (busy %b) at %0t",
                         rd_addr4, m_rd_k, m_busy, $time);
            end
            m_rd_k++;
            m_out++;
            n_reads++;
        end
        checks++;
        if (m_out > 2 || m_out < 0) begin
            errors++; $display("FAIL credit: got outstanding %0d expected 0..2 at %0t", m_out, $time);
        end
        if (done4 === 1'b1) n_done++;
        p_hold = (valid4 === 1'b1) && !rdy;
        p_data = data4; p_row = row4; p_last = last4;
        m_done_exp = popped_last;
        if (m_busy && popped_last) begin
            m_busy = 0;
        end else if (!m_busy && st) begin
            m_busy = 1; m_rd_k = 0; m_pop_k = 0;
        end
    endtask

    // mode 0: ready high, 1: alternating, 2: random ready plus ignored starts
    task automatic run_to_idle(input int mode, input int limit);
        int i;
        bit rdy, st;
        i = 0;
        while ((m_busy || m_done_exp) && i < limit) begin
            st = 0;
            case (mode)
                0:       rdy = 1;
                1:       rdy = (i % 2 == 0);
                default: begin
                    rdy = ($urandom_range(0, 2) != 0);
                    st  = m_busy && ($urandom_range(0, 3) == 0);
                end
            endcase
            step4(st, rdy);
            i++;
        end
        checks++;
        if (m_busy || m_done_exp) begin
            errors++; $display("FAIL timeout: got busy after %0d cycles expected idle", limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1; start4 = 0; ready4 = 0; start1 = 0; ready1 = 0; mem1_word = 8'h00;
        #1 rst_n = 0;
        #2;
        checks++;
        if ({busy4, done4, rd_en4, rd_addr4, valid4, data4, row4, last4} !== 16'h0) begin
            errors++;
            $display("FAIL reset4: got %h expected 0",
                     {busy4, done4, rd_en4, rd_addr4, valid4, data4, row4, last4});
        end
        checks++;
        if ({busy1, done1, rd_en1, rd_addr1, valid1, data1, row1, last1} !== 14'h0) begin
            errors++;
            $display("FAIL reset1: got %h expected 0",
                     {busy1, done1, rd_en1, rd_addr1, valid1, data1, row1, last1});
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_streaming();
        int first_v, last_v, done_c, first_rd, last_rd;
        for (int unsigned i = 0; i < 4; i++) mem4[i] = 8'hA0 + 8'(i);
        clear_counts();
        first_v = -1; last_v = -1; done_c = -1; first_rd = -1; last_rd = -1;
        for (int c = 0; c < 10; c++) begin
            step4(c == 0, 1'b1);
            if (o_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (o_rd) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (o_done) done_c = c;
        end
        checks++;
        if (first_v != 3 || last_v != 6) begin
            errors++; $display("FAIL stream_window: got %0d..%0d expected 3..6", first_v, last_v);
        end
        checks++;
        if (first_rd != 1 || last_rd != 4 || n_reads != 4) begin
            errors++;
            $display("FAIL stream_reads: got %0d..%0d n=%0d expected 1..4 n=4", first_rd, last_rd, n_reads);
        end
        checks++;
        if (done_c != 7 || n_done != 1 || n_pops != 4) begin
            errors++;
            $display("FAIL stream_done: got cycle %0d n=%0d pops=%0d expected 7 1 4", done_c, n_done, n_pops);
        end
    endtask

    task automatic test_backpressure();
        clear_counts();
        step4(1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) step4(1'b0, 1'b0);
        checks++;
        if (n_reads != 2) begin
            errors++; $display("FAIL bp_reads: got %0d expected 2", n_reads);
        end
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hA0) begin
            errors++; $display("FAIL bp_head: got v%b %h expected v1 a0", o_valid, o_data);
        end
        run_to_idle(0, 40);
        checks++;
        if (n_pops != 4 || n_done != 1 || n_reads != 4) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d done=%0d reads=%0d expected 4 1 4", n_pops, n_done, n_reads);
        end
    endtask

    task automatic test_toggle();
        clear_counts();
        step4(1'b1, 1'b1);
        run_to_idle(1, 60);
        checks++;
        if (n_pops != 4 || n_done != 1) begin
            errors++; $display("FAIL toggle: got pops=%0d done=%0d expected 4 1", n_pops, n_done);
        end
    endtask

    task automatic test_start_ignored();
        int i;
        clear_counts();
        step4(1'b1, 1'b1);
        step4(1'b1, 1'b1);
        step4(1'b0, 1'b1);
        step4(1'b0, 1'b1);
        step4(1'b1, 1'b1);
        i = 0;
        while (!m_done_exp && i < 30) begin
            step4(1'b0, 1'b1);
            i++;
        end
        step4(1'b1, 1'b1);
        checks++;
        if (o_done !== 1'b1 || n_reads != 4) begin
            errors++; $display("FAIL restart_done: got done=%b reads=%0d expected 1 4", o_done, n_reads);
        end
        step4(1'b0, 1'b1);
        checks++;
        if (o_rd !== 1'b1 || n_reads != 5) begin
            errors++; $display("FAIL restart_issue: got rd_en=%b reads=%0d expected 1 5", o_rd, n_reads);
        end
        run_to_idle(0, 40);
        checks++;
        if (n_reads != 8 || n_done != 2 || n_pops != 8) begin
            errors++;
            $display("FAIL restart_total: got reads=%0d done=%0d pops=%0d expected 8 2 8", n_reads, n_done, n_pops);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        clear_counts();
        step4(1'b1, 1'b1);
        i = 0;
        while (n_pops < 2 && i < 20) begin
            step4(1'b0, 1'b1);
            i++;
        end
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        checks++;
        if ({busy4, done4, rd_en4, rd_addr4, valid4, data4, row4, last4} !== 16'h0) begin
            errors++;
            $display("FAIL midreset: got %h expected 0",
                     {busy4, done4, rd_en4, rd_addr4, valid4, data4, row4, last4});
        end
        model_reset();
        clear_counts();
        for (int c = 0; c < 3; c++) step4(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1;
        step4(1'b1, 1'b1);
        run_to_idle(0, 40);
        checks++;
        if (n_pops != 4 || n_done != 1) begin
            errors++; $display("FAIL midreset_frame: got pops=%0d done=%0d expected 4 1", n_pops, n_done);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int unsigned i = 0; i < 4; i++) mem4[i] = 8'($urandom);
            clear_counts();
            step4(1'b1, 1'($urandom_range(0, 1)));
            run_to_idle(2, 200);
            checks++;
            if (n_pops != 4 || n_done != 1 || n_reads != 4) begin
                errors++;
                $display("FAIL random_frame%0d: got pops=%0d done=%0d reads=%0d expected 4 1 4",
                         f, n_pops, n_done, n_reads);
            end
        end
    endtask

    task automatic test_single();
        bit exp_v;
        mem1_word = 8'($urandom);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start1 = (c == 0);
            ready1 = 1'b1;
            #1;
            exp_v = (c == 3);
            checks++;
            if (valid1 !== exp_v || (exp_v && (data1 !== mem1_word || row1 !== 1'b0 || last1 !== 1'b1))) begin
                errors++;
                $display("FAIL single_beat c%0d: got v%b %h/%0d/%b expected v%b %h/0/1",
                         c, valid1, data1, row1, last1, exp_v, mem1_word);
            end
            checks++;
            if (done1 !== (c == 4) || busy1 !== (c >= 1 && c <= 3)) begin
                errors++;
                $display("FAIL single_ctl c%0d: got done=%b busy=%b expected %b %b",
                         c, done1, busy1, (c == 4), (c >= 1 && c <= 3));
            end
            checks++;
            if (rd_en1 !== (c == 1) || (rd_en1 === 1'b1 && rd_addr1 !== 1'b0)) begin
                errors++;
                $display("FAIL single_read c%0d: got rd_en=%b addr=%0d expected %b 0", c, rd_en1, rd_addr1, (c == 1));
            end
        end
        start1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_toggle();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
